// File: rtl/wb_cmd_pkg.sv
// Shared opcodes, FSM states and the command-word builder for the
// wishbone command sequencer.
package wb_cmd_pkg;

  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_ADDR = 2'b10;
  localparam logic [1:0] RSP_OK   = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_WAIT = 3'd2,
    ST_XFER      = 3'd3,
    ST_XFER_WAIT = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  // Set-address carries the increment enable and a constant 1 marker bit.
  function automatic logic [33:0] build_cmd(input logic [1:0]  op,
                                            input logic        inc,
                                            input logic [29:0] addr,
                                            input logic [31:0] wdata);
    case (op)
      CMD_ADDR: return {CMD_ADDR, inc, 1'b1, addr};
      CMD_WR:   return {CMD_WR, wdata};
      default:  return {CMD_RD, 32'h0};
    endcase
  endfunction

endpackage

// File: rtl/wb_cmd_sequencer_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after ptr,
// wrapping around NCH.
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int PW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0]  gnt_idx,
  output logic           any
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/wb_cmd_sequencer.sv
// Multi-channel word access sequencer: arbitrates requesters and turns each
// access into set-address/read/write commands on the 34-bit command bus.
module wb_cmd_sequencer
  import wb_cmd_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int AW       = 30,
  parameter int INC_MODE = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH-1:0]    req_we,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*32-1:0] req_wdata,
  output logic [NCH-1:0]    resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              cmd_stb,
  output logic [33:0]       cmd_word,
  input  logic              cmd_busy,
  input  logic              rsp_stb,
  input  logic [33:0]       rsp_word,
  output logic [2:0]        dbg_state
);

  localparam int   PW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic INC_BIT = (INC_MODE != 0);
  localparam bit   TO_EN   = (TIMEOUT != 0);

  // Handshake: a request on channel i is taken in the cycle where
  // req_valid[i] && req_ready[i]; req_ready is only ever high in IDLE.
  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, g_q, g_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d, sh_addr_q, sh_addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             sh_vld_q, sh_vld_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             cmd_stb_q, cmd_stb_d;
  logic [33:0]      cmd_word_q, cmd_word_d;
  logic [NCH-1:0]   resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;

  logic [NCH-1:0]   arb_gnt;
  logic [PW-1:0]    arb_idx;
  logic             arb_any;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [31:0]      sel_wdata;
  logic             shadow_hit, rsp_ok, timed_out;

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign sel_we     = req_we[arb_idx];
  assign sel_addr   = req_addr[int'(arb_idx)*AW +: AW];
  assign sel_wdata  = req_wdata[int'(arb_idx)*32 +: 32];
  assign shadow_hit = sh_vld_q && (sh_addr_q == sel_addr);
  assign rsp_ok     = (rsp_word[33:32] == RSP_OK);
  // The accept and command cycles count toward the budget, so the wait
  // states give up two counts early.
  assign timed_out  = TO_EN && ((32'(cnt_q) + 32'd2) >= 32'(TIMEOUT));

  assign req_ready  = (state_q == ST_IDLE) ? arb_gnt : '0;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign cmd_stb    = cmd_stb_q;
  assign cmd_word   = cmd_word_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    g_d          = g_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sh_addr_d    = sh_addr_q;
    sh_vld_d     = sh_vld_q;
    cnt_d        = cnt_q;
    cmd_stb_d    = cmd_stb_q;
    cmd_word_d   = cmd_word_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          g_d       = arb_idx;
          ptr_d     = (arb_idx == PW'(NCH - 1)) ? '0 : arb_idx + PW'(1);
          we_d      = sel_we;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          cmd_stb_d = 1'b1;
          if (shadow_hit) begin
            state_d    = ST_XFER;
            cmd_word_d = build_cmd(sel_we ? CMD_WR : CMD_RD, 1'b0, 30'd0, sel_wdata);
          end else begin
            state_d    = ST_ADDR;
            cmd_word_d = build_cmd(CMD_ADDR, INC_BIT, 30'(sel_addr), 32'h0);
          end
        end
      end
      ST_ADDR, ST_XFER: begin
        if (!cmd_busy) begin
          cmd_stb_d = 1'b0;
          cnt_d     = '0;
          state_d   = (state_q == ST_ADDR) ? ST_ADDR_WAIT : ST_XFER_WAIT;
        end
      end
      ST_ADDR_WAIT, ST_XFER_WAIT: begin
        cnt_d = (cnt_q != '1) ? cnt_q + 16'd1 : cnt_q;
        if (rsp_stb && state_q == ST_ADDR_WAIT && rsp_ok) begin
          sh_addr_d  = addr_q;
          sh_vld_d   = 1'b1;
          state_d    = ST_XFER;
          cmd_stb_d  = 1'b1;
          cmd_word_d = build_cmd(we_q ? CMD_WR : CMD_RD, 1'b0, 30'd0, wdata_q);
        end else if (rsp_stb) begin
          resp_rdata_d = (state_q == ST_XFER_WAIT) ? rsp_word[31:0] : 32'h0;
          resp_err_d   = !rsp_ok;
          resp_valid_d = NCH'(1) << g_q;
          state_d      = ST_DONE;
          if (!rsp_ok) sh_vld_d = 1'b0;
          else if (INC_BIT) sh_addr_d = sh_addr_q + AW'(1);
        end else if (timed_out) begin
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b1;
          resp_valid_d = NCH'(1) << g_q;
          sh_vld_d     = 1'b0;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      g_q          <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sh_addr_q    <= '0;
      sh_vld_q     <= 1'b0;
      cnt_q        <= '0;
      cmd_stb_q    <= 1'b0;
      cmd_word_q   <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      g_q          <= g_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sh_addr_q    <= sh_addr_d;
      sh_vld_q     <= sh_vld_d;
      cnt_q        <= cnt_d;
      cmd_stb_q    <= cmd_stb_d;
      cmd_word_q   <= cmd_word_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
